// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM encoding, ALU flag bit positions and channel indices.
package alu_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int FLAG_WIDTH     = 5;
    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_CARRY     = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_NEGATIVE  = 3;
    localparam int FLAG_EXCEPTION = 4;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int OPS_WIDTH = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and status signals of the ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
);
    import alu_arb_pkg::*;

    logic                    i_req0, i_req1;
    logic [DATA_WIDTH-1:0]   i_operandA0, i_operandA1;
    logic [DATA_WIDTH-1:0]   i_operandB0, i_operandB1;
    logic [OPCODE_WIDTH-1:0] i_opcode0, i_opcode1;
    logic                    o_gnt0, o_gnt1;
    logic                    o_done0, o_done1;
    logic [DATA_WIDTH-1:0]   o_result0, o_result1;
    logic [FLAG_WIDTH-1:0]   o_flags0, o_flags1;

    logic [DATA_WIDTH-1:0]   o_operandA, o_operandB;
    logic [OPCODE_WIDTH-1:0] o_opcode;
    logic [DATA_WIDTH-1:0]   i_result;
    logic                    i_zero, i_carry, i_overflow, i_negative, i_exception;

    logic                    o_busy;

    modport slave (
        input  i_req0, i_req1, i_operandA0, i_operandA1, i_operandB0, i_operandB1,
        input  i_opcode0, i_opcode1,
        output o_gnt0, o_gnt1, o_done0, o_done1, o_result0, o_result1, o_flags0, o_flags1,
        output o_operandA, o_operandB, o_opcode,
        input  i_result, i_zero, i_carry, i_overflow, i_negative, i_exception,
        output o_busy
    );

    modport master (
        output i_req0, i_req1, i_operandA0, i_operandA1, i_operandB0, i_operandB1,
        output i_opcode0, i_opcode1,
        input  o_gnt0, o_gnt1, o_done0, o_done1, o_result0, o_result1, o_flags0, o_flags1,
        input  o_operandA, o_operandB, o_opcode,
        output i_result, i_zero, i_carry, i_overflow, i_negative, i_exception,
        input  o_busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arbiter_2
    import alu_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        winner = CH0;
        grant  = 2'b00;
        unique case (req)
            2'b01:   winner = CH0;
            2'b10:   winner = CH1;
            2'b11:   winner = ~last_grant;
            default: winner = CH0;
        endcase
        if (req != 2'b00) begin
            grant = (winner == CH1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters with round-robin grants.
// Define ALU_ARB_STATS_EN to add saturating per-channel completion counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int ALU_LATENCY  = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [OPS_WIDTH-1:0] o_ops0,
    output logic [OPS_WIDTH-1:0] o_ops1
`endif
);

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

    state_t                  state;
    logic                    last_grant;
    logic                    owner;
    logic [2:0]              cnt;
    logic [1:0]              req;
    logic [1:0]              grant;
    logic                    winner;
    logic                    finish;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b;
    logic [OPCODE_WIDTH-1:0] sel_op;
    logic [FLAG_WIDTH-1:0]   alu_flags;

    assign req = {bus.i_req1, bus.i_req0};

    rr_arbiter_2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );

    assign sel_a  = (winner == CH1) ? bus.i_operandA1 : bus.i_operandA0;
    assign sel_b  = (winner == CH1) ? bus.i_operandB1 : bus.i_operandB0;
    assign sel_op = (winner == CH1) ? bus.i_opcode1   : bus.i_opcode0;

    always_comb begin
        alu_flags                 = '0;
        alu_flags[FLAG_ZERO]      = bus.i_zero;
        alu_flags[FLAG_CARRY]     = bus.i_carry;
        alu_flags[FLAG_OVERFLOW]  = bus.i_overflow;
        alu_flags[FLAG_NEGATIVE]  = bus.i_negative;
        alu_flags[FLAG_EXCEPTION] = bus.i_exception;
    end

    assign finish     = (state == WAIT) && (cnt == 3'd0);
    assign bus.o_busy = (state == WAIT);

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            last_grant     <= CH1;
            owner          <= CH0;
            cnt            <= '0;
            bus.o_gnt0     <= 1'b0;
            bus.o_gnt1     <= 1'b0;
            bus.o_done0    <= 1'b0;
            bus.o_done1    <= 1'b0;
            bus.o_result0  <= '0;
            bus.o_result1  <= '0;
            bus.o_flags0   <= '0;
            bus.o_flags1   <= '0;
            bus.o_operandA <= '0;
            bus.o_operandB <= '0;
            bus.o_opcode   <= '0;
        end else begin
            bus.o_gnt0  <= 1'b0;
            bus.o_gnt1  <= 1'b0;
            bus.o_done0 <= 1'b0;
            bus.o_done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        bus.o_operandA <= sel_a;
                        bus.o_operandB <= sel_b;
                        bus.o_opcode   <= sel_op;
                        last_grant     <= winner;
                        owner          <= winner;
                        bus.o_gnt0     <= grant[0];
                        bus.o_gnt1     <= grant[1];
                        cnt            <= LAT_LOAD;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // Requests are not looked at here; a held req is a new command next IDLE.
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        if (owner == CH0) begin
                            bus.o_result0 <= bus.i_result;
                            bus.o_flags0  <= alu_flags;
                            bus.o_done0   <= 1'b1;
                        end else begin
                            bus.o_result1 <= bus.i_result;
                            bus.o_flags1  <= alu_flags;
                            bus.o_done1   <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [OPS_WIDTH-1:0] ops0_q, ops1_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ops0_q <= '0;
            ops1_q <= '0;
        end else if (finish) begin
            if ((owner == CH0) && (ops0_q != {OPS_WIDTH{1'b1}})) ops0_q <= ops0_q + 1'b1;
            if ((owner == CH1) && (ops1_q != {OPS_WIDTH{1'b1}})) ops1_q <= ops1_q + 1'b1;
        end
    end

    assign o_ops0 = ops0_q;
    assign o_ops1 = ops1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, per-channel scoreboards
// fed at stimulus time, a latency-1 ALU model and multi-cycle corner sequences.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW  = 8;
    localparam int OW  = 4;
    localparam int LAT = 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_BAD = 4'hF;

    typedef struct {
        logic       ch;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] res;
        logic [4:0] flg;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [4:0] flg;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] ops0, ops1;
`endif

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ALU_LATENCY(LAT)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .o_ops0  (ops0),
        .o_ops1  (ops1)
`endif
    );

    // Reference ALU: returns {flags, result}; flags are {exc, neg, ovf, carry/borrow, zero}.
    function automatic logic [12:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic [4:0] f;
        f = '0;
        r = '0;
        w = '0;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                f[1] = w[8];
                f[2] = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0];
                f[1] = w[8];
                f[2] = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: f[4] = 1'b1;
        endcase
        if (!f[4]) begin
            f[0] = (r == 8'h00);
            f[3] = r[7];
        end
        return {f, r};
    endfunction

    logic [12:0] alu_q = '0;
    always @(posedge clk) alu_q <= alu_fn(bus.o_operandA, bus.o_operandB, bus.o_opcode);
    assign bus.i_result    = alu_q[7:0];
    assign bus.i_zero      = alu_q[8];
    assign bus.i_carry     = alu_q[9];
    assign bus.i_overflow  = alu_q[10];
    assign bus.i_negative  = alu_q[11];
    assign bus.i_exception = alu_q[12];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    exp_t sb0[$];
    exp_t sb1[$];
    int   grant_log[$];
    int   cyc = 0;
    int   gnt_cyc0 = 0, gnt_cyc1 = 0, done_cyc0 = 0, done_cyc1 = 0, done_total = 0;
    logic prev_g0 = 1'b0, prev_g1 = 1'b0;
    logic [7:0] last_res0 = '0, last_res1 = '0;
    logic [4:0] last_flg0 = '0, last_flg1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: grant bookkeeping and scoreboard comparison on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_gnt0 || bus.o_gnt1) check("gnt_onehot", 32'(bus.o_gnt0 & bus.o_gnt1), 32'd0);
        if (bus.o_gnt0) begin
            check("gnt0_single_cycle", 32'(prev_g0), 32'd0);
            grant_log.push_back(0);
            gnt_cyc0 = cyc;
        end
        if (bus.o_gnt1) begin
            check("gnt1_single_cycle", 32'(prev_g1), 32'd0);
            grant_log.push_back(1);
            gnt_cyc1 = cyc;
        end
        if (bus.o_done0) begin
            done_total++;
            done_cyc0 = cyc;
            check("done0_latency", 32'(cyc - gnt_cyc0), 32'(LAT + 1));
            check("done0_has_expected", 32'(sb0.size() != 0), 32'd1);
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                check("result0", 32'(bus.o_result0), 32'(e.res));
                check("flags0", 32'(bus.o_flags0), 32'(e.flg));
                last_res0 = e.res;
                last_flg0 = e.flg;
            end
            check("result1_held", 32'(bus.o_result1), 32'(last_res1));
            check("flags1_held", 32'(bus.o_flags1), 32'(last_flg1));
        end
        if (bus.o_done1) begin
            done_total++;
            done_cyc1 = cyc;
            check("done1_latency", 32'(cyc - gnt_cyc1), 32'(LAT + 1));
            check("done1_has_expected", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                check("result1", 32'(bus.o_result1), 32'(e.res));
                check("flags1", 32'(bus.o_flags1), 32'(e.flg));
                last_res1 = e.res;
                last_flg1 = e.flg;
            end
            check("result0_held", 32'(bus.o_result0), 32'(last_res0));
            check("flags0_held", 32'(bus.o_flags0), 32'(last_flg0));
        end
        prev_g0 = bus.o_gnt0;
        prev_g1 = bus.o_gnt1;
    end

    task automatic set_cmd(input logic ch, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic req);
        if (ch == CH0) begin
            bus.i_req0 = req; bus.i_operandA0 = a; bus.i_operandB0 = b; bus.i_opcode0 = op;
        end else begin
            bus.i_req1 = req; bus.i_operandA1 = a; bus.i_operandB1 = b; bus.i_opcode1 = op;
        end
    endtask

    task automatic push_exp(input logic ch, input logic [7:0] r, input logic [4:0] f);
        exp_t e;
        e.res = r;
        e.flg = f;
        if (ch == CH0) sb0.push_back(e);
        else           sb1.push_back(e);
    endtask

    task automatic wait_gnt(input logic ch, input string name);
        logic found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = (ch == CH0) ? bus.o_gnt0 : bus.o_gnt1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic drain(input string name);
        logic found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            found = (sb0.size() == 0) && (sb1.size() == 0) && !bus.o_busy;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic do_op(input logic ch, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [7:0] r, input logic [4:0] f);
        push_exp(ch, r, f);
        set_cmd(ch, a, b, op, 1'b1);
        wait_gnt(ch, "op_gnt_timeout");
        set_cmd(ch, 8'h00, 8'h00, 4'h0, 1'b0);
        drain("op_done_timeout");
    endtask

    // Keeps req high across grants, presenting a fresh command each time gnt is seen.
    task automatic run_chan(input logic ch, input int n);
        logic [7:0]  a, b;
        logic [3:0]  op;
        logic [12:0] m;
        for (int k = 0; k < n; k++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 4'(k % 4);
            m  = alu_fn(a, b, op);
            push_exp(ch, m[7:0], m[12:8]);
            set_cmd(ch, a, b, op, 1'b1);
            wait_gnt(ch, "chan_gnt_timeout");
        end
        set_cmd(ch, 8'h00, 8'h00, 4'h0, 1'b0);
    endtask

    task automatic clear_held();
        last_res0 = '0; last_res1 = '0;
        last_flg0 = '0; last_flg1 = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, 32'({bus.o_gnt0, bus.o_gnt1, bus.o_done0, bus.o_done1, bus.o_busy}), 32'd0);
        check({tag, "_results"}, 32'({bus.o_result0, bus.o_result1}), 32'd0);
        check({tag, "_flags"}, 32'({bus.o_flags0, bus.o_flags1}), 32'd0);
        check({tag, "_alu_drive"}, 32'({bus.o_operandA, bus.o_operandB, bus.o_opcode}), 32'd0);
    endtask

    vec_t vecs[8];
    int   saved_done;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{CH0, 8'h05, 8'h03, OP_ADD, 8'h08, 5'b00000};
        vecs[1] = '{CH1, 8'h04, 8'h04, OP_SUB, 8'h00, 5'b00001};
        vecs[2] = '{CH0, 8'h03, 8'h05, OP_SUB, 8'hFE, 5'b01010};
        vecs[3] = '{CH1, 8'h7F, 8'h01, OP_ADD, 8'h80, 5'b01100};
        vecs[4] = '{CH0, 8'hFF, 8'h01, OP_ADD, 8'h00, 5'b00011};
        vecs[5] = '{CH1, 8'hF0, 8'h3C, OP_AND, 8'h30, 5'b00000};
        vecs[6] = '{CH0, 8'hAA, 8'hAA, OP_XOR, 8'h00, 5'b00001};
        vecs[7] = '{CH1, 8'h12, 8'h34, OP_BAD, 8'h00, 5'b10000};

        set_cmd(CH0, 8'h00, 8'h00, 4'h0, 1'b0);
        set_cmd(CH1, 8'h00, 8'h00, 4'h0, 1'b0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests from the table, alternating channels.
        foreach (vecs[i]) begin
            do_op(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg);
        end

        // Both requesters held for three commands each: grants must alternate starting with 0.
        grant_log.delete();
        fork
            run_chan(CH0, 3);
            run_chan(CH1, 3);
        join
        drain("contend_drain");
        check("contend_grant_count", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < grant_log.size(); k++) check("contend_grant_order", 32'(grant_log[k]), 32'(k % 2));

        // req1 raised while channel 0 is in WAIT: gnt1 must follow done0 by exactly one cycle.
        push_exp(CH0, 8'h30, 5'b00000);
        set_cmd(CH0, 8'h10, 8'h20, OP_ADD, 1'b1);
        wait_gnt(CH0, "late_gnt0_timeout");
        set_cmd(CH0, 8'h00, 8'h00, 4'h0, 1'b0);
        push_exp(CH1, 8'h09, 5'b00000);
        set_cmd(CH1, 8'h0A, 8'h01, OP_SUB, 1'b1);
        wait_gnt(CH1, "late_gnt1_timeout");
        set_cmd(CH1, 8'h00, 8'h00, 4'h0, 1'b0);
        drain("late_drain");
        check("late_gnt1_after_done0", 32'(gnt_cyc1 - done_cyc0), 32'd1);

        // Reset while an operation is in WAIT: outputs clear at once and no done follows.
        set_cmd(CH0, 8'h11, 8'h22, OP_ADD, 1'b1);
        wait_gnt(CH0, "rst_gnt0_timeout");
        set_cmd(CH0, 8'h00, 8'h00, 4'h0, 1'b0);
        saved_done = done_total;
        #2 rst_n = 1'b0;
        clear_held();
        #1 check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_done", 32'(done_total), 32'(saved_done));

        grant_log.delete();
        fork
            run_chan(CH0, 1);
            run_chan(CH1, 1);
        join
        drain("post_rst_drain");
        check("post_rst_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 0) check("post_rst_first_grant", 32'(grant_log[0]), 32'd0);

`ifdef ALU_ARB_STATS_EN
        @(negedge clk) rst_n = 1'b0;
        clear_held();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ops_reset", 32'({ops0, ops1}), 32'd0);
        do_op(CH0, 8'h01, 8'h01, OP_ADD, 8'h02, 5'b00000);
        do_op(CH1, 8'h01, 8'h01, OP_AND, 8'h01, 5'b00000);
        do_op(CH0, 8'h02, 8'h01, OP_SUB, 8'h01, 5'b00000);
        do_op(CH1, 8'h0F, 8'h0F, OP_XOR, 8'h00, 5'b00001);
        do_op(CH0, 8'h80, 8'h80, OP_ADD, 8'h00, 5'b00111);
        check("ops0_count", 32'(ops0), 32'd3);
        check("ops1_count", 32'(ops1), 32'd2);
        force dut.ops0_q = 16'hFFFF;
        #1 release dut.ops0_q;
        do_op(CH0, 8'h01, 8'h02, OP_ADD, 8'h03, 5'b00000);
        check("ops0_saturate", 32'(ops0), 32'hFFFF);
        check("ops1_untouched", 32'(ops1), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter that shares the single registered ALU between two requesters, for example the UART command interface and a second command source.
- Each requester presents operand A, operand B and opcode with a request and receives a grant pulse.
- Each requester later receives a done pulse with the held result and flags.
- Sits between the requesters and the ALU instance; it drives the ALU's operand and opcode inputs and samples its result and flag outputs.

Parameters:
- DATA_WIDTH, 8, width of operands and result.
- OPCODE_WIDTH, 4, width of the ALU opcode.
- ALU_LATENCY, 1, clock edges from operands applied to ALU result valid; legal range 0..7 (0 = combinational ALU).

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_req0 / i_req1  in  1  request from requester 0 / 1.
- i_operandA0 / i_operandA1  in  DATA_WIDTH  operand A per requester.
- i_operandB0 / i_operandB1  in  DATA_WIDTH  operand B per requester.
- i_opcode0 / i_opcode1  in  OPCODE_WIDTH  opcode per requester.
- o_gnt0 / o_gnt1  out  1  one-cycle grant; operands were captured.
- o_done0 / o_done1  out  1  one-cycle result-valid pulse.
- o_result0 / o_result1  out  DATA_WIDTH  result, held until that channel's next done.
- o_flags0 / o_flags1  out  5  {exception, negative, overflow, carry, zero}, held like the result.
- o_operandA, o_operandB  out  DATA_WIDTH  to ALU.
- o_opcode  out  OPCODE_WIDTH  to ALU.
- i_result  in  DATA_WIDTH  from ALU.
- i_zero, i_carry, i_overflow, i_negative, i_exception  in  1 each  ALU flags.
- o_busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE, last_grant=1, so requester 0 wins first.
  - All o_gnt*, o_done* and o_busy = 0.
  - o_result*, o_flags*, o_operandA/B and o_opcode = 0.
- States: IDLE, WAIT.
- IDLE, at a rising edge with any request high:
  - Select the winner: the only requester asserting, or if both assert, the one that is not last_grant.
  - Latch its operands/opcode into o_operandA/B/o_opcode and update last_grant.
  - Assert o_gnt of the winner for exactly the next cycle.
  - Load cnt=ALU_LATENCY and go to WAIT.
- IDLE with no request: outputs hold their values and the state stays IDLE.
- WAIT:
  - Requests are ignored.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture i_result and the flags into the winner's o_result/o_flags, pulse its o_done for one cycle, and return to IDLE.
- Timing:
  - o_done rises ALU_LATENCY+1 cycles after o_gnt rises.
  - Throughput is one operation per ALU_LATENCY+2 cycles.
- Handshake:
  - A requester holds req and operands stable until it sees gnt.
  - It deasserts req, or presents a new command, in the cycle gnt is high.
  - A req still high at that edge is sampled only in the next IDLE and counts as a new command.
- Done and a new grant may overlap: o_done is high in the same cycle the next IDLE arbitration edge occurs.
- No starvation: with both requesters asserting continuously, grants strictly alternate 0,1,0,1.
- Reset mid-operation: the in-flight operation is discarded, no done is issued, and last_grant returns to 1.
- The other channel's o_result/o_flags are never disturbed by a response to this channel.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined, adds outputs o_ops0 and o_ops1, 16 bits each.
  - Each counts completed operations (done pulses) for its channel.
  - Counts saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - the state encoding (IDLE, WAIT);
  - flag bit indices (FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVERFLOW=2, FLAG_NEGATIVE=3, FLAG_EXCEPTION=4);
  - channel index constants CH0=0 and CH1=1.
- Sub-module rr_arbiter_2 is purely combinational:
  - inputs req[1:0] and last_grant;
  - outputs a one-hot grant and the winner index.
- The FSM, latency counter and output registers stay in alu_arbiter.

Test Plan:
- Reset release, then req0 with A=8'h05, B=8'h03, ADD; ALU_LATENCY=1.
  - o_gnt0 one cycle; o_done0 two cycles later.
  - o_result0=8'h08, o_flags0=5'b00000; requester 1 outputs remain 0.
- req0 and req1 asserted in the same cycle.
  - Grant to 0 first, then to 1 on the next IDLE edge.
  - With both held continuously for 6 operations, the grant order is 0,1,0,1,0,1.
- req1 with SUB, A=8'h04, B=8'h04.
  - o_done1 with o_result1=8'h00 and o_flags1 zero bit=1.
  - o_result0 unchanged from its previous value.
- req1 raised during WAIT of a channel-0 operation.
  - No o_gnt1 until after o_done0.
  - o_gnt1 appears exactly in the cycle following o_done0's edge.
- i_reset pulled low during WAIT.
  - All outputs go 0 immediately (asynchronously) and no done follows.
  - The first grant after release goes to requester 0.
- ALU_ARB_STATS_EN defined: 3 operations on ch0 and 2 on ch1 give o_ops0=3 and o_ops1=2; forcing the count to 16'hFFFF and completing one more operation keeps it at 16'hFFFF.
